// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction/memory inputs and datapath strobes of the control sequencer
interface control_sequencer_if #(parameter int DATA_WIDTH = 32);
  logic run, mem_ready, con_ff;
  logic [DATA_WIDTH-1:0] ControlIn;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
  logic Read, Write;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin;
  logic [4:0] alu_op;
  logic instr_done, halted, fault;
  modport master (
    input run, mem_ready, con_ff, ControlIn,
    output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
    output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
    output alu_op, instr_done, halted, fault
  );
  modport slave (
    output run, mem_ready, con_ff, ControlIn,
    input PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
    input Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin,
    input alu_op, instr_done, halted, fault
  );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute control FSM driving datapath strobes
module control_sequencer #(
  parameter int OP_MSB = 31,
  parameter int OP_LSB = 27
) (
  input logic clock,
  input logic clear,
  control_sequencer_if.master bus
);
  typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, T7, HALT, FAULT} state_t;
  state_t state, nxt;
  logic [4:0] op;
  logic is_r, is_imm, is_ldi, is_ld, is_st, is_br, is_nop, is_halt, legal, done;
  assign op = bus.ControlIn[OP_MSB:OP_LSB];
  assign is_r = op >= 5'd3 && op <= 5'd11;
  assign is_imm = op >= 5'd12 && op <= 5'd14;
  assign is_ldi = op == 5'd1;
  assign is_ld = op == 5'd0;
  assign is_st = op == 5'd2;
  assign is_br = op == 5'd19;
  assign is_nop = op == 5'd26;
  assign is_halt = op == 5'd27;
  assign legal = is_r | is_imm | is_ldi | is_ld | is_st | is_br | is_nop | is_halt;
  always_ff @(posedge clock or negedge clear)
    if (!clear) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    done = 1'b0;
    bus.PCout = 1'b0;
    bus.PCin = 1'b0;
    bus.IncPC = 1'b0;
    bus.MARin = 1'b0;
    bus.MDRin = 1'b0;
    bus.MDRout = 1'b0;
    bus.IRin = 1'b0;
    bus.Yin = 1'b0;
    bus.Zin = 1'b0;
    bus.Zlowout = 1'b0;
    bus.Read = 1'b0;
    bus.Write = 1'b0;
    bus.Gra = 1'b0;
    bus.Grb = 1'b0;
    bus.Grc = 1'b0;
    bus.Rin = 1'b0;
    bus.Rout = 1'b0;
    bus.BAout = 1'b0;
    bus.Cout = 1'b0;
    bus.CONin = 1'b0;
    bus.alu_op = 5'd0;
    bus.halted = 1'b0;
    bus.fault = 1'b0;
    case (state)
      IDLE: nxt = bus.run ? T0 : IDLE;
      T0: begin
        {bus.PCout, bus.MARin, bus.IncPC, bus.Zin} = 4'hf;
        nxt = T1;
      end
      T1: begin
        {bus.Zlowout, bus.PCin, bus.Read, bus.MDRin} = 4'hf;
        nxt = bus.mem_ready ? T2 : T1;
      end
      T2: begin
        {bus.MDRout, bus.IRin} = 2'b11;
        nxt = T3;
      end
      T3: begin
        nxt = is_halt ? HALT : !legal ? FAULT : T4;
        done = is_nop;
        if (is_br) {bus.Gra, bus.Rout, bus.CONin} = 3'b111;
        else if (legal && !is_nop && !is_halt) begin
          {bus.Grb, bus.Yin} = 2'b11;
          bus.Rout = is_r | is_imm;
          bus.BAout = !(is_r | is_imm);
        end
      end
      T4: begin
        nxt = T5;
        if (is_br) {bus.PCout, bus.Yin} = 2'b11;
        else begin
          bus.Zin = 1'b1;
          {bus.Grc, bus.Rout} = {2{is_r}};
          bus.Cout = !is_r;
          bus.alu_op = is_r ? op : op == 5'd13 ? 5'd5 : op == 5'd14 ? 5'd6 : 5'd3;
        end
      end
      T5: begin
        nxt = T6;
        if (is_br) begin
          {bus.Cout, bus.Zin} = 2'b11;
          bus.alu_op = 5'd3;
        end else begin
          bus.Zlowout = 1'b1;
          bus.MARin = is_ld | is_st;
          {bus.Gra, bus.Rin} = {2{!(is_ld | is_st)}};
          done = !(is_ld | is_st);
        end
      end
      T6: begin
        nxt = T7;
        if (is_br) begin
          {bus.Zlowout, bus.PCin} = {2{bus.con_ff}};
          done = 1'b1;
        end else if (is_ld) begin
          {bus.Read, bus.MDRin} = 2'b11;
          nxt = bus.mem_ready ? T7 : T6;
        end else {bus.Gra, bus.Rout, bus.MDRin} = 3'b111;
      end
      T7: begin
        done = 1'b1;
        if (is_ld) {bus.MDRout, bus.Gra, bus.Rin} = 3'b111;
        else bus.Write = 1'b1;
      end
      HALT: bus.halted = 1'b1;
      FAULT: bus.fault = 1'b1;
      default: nxt = IDLE;
    endcase
    // a store's final step doubles as its memory wait, so it only retires on mem_ready
    if (done && (state != T7 || is_ld || bus.mem_ready)) nxt = bus.run ? T0 : IDLE;
    bus.instr_done = done;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: random and directed instruction streams against a per-step strobe table model
module tb_control_sequencer;
  typedef logic [27:0] vec_t;
  typedef struct packed {vec_t v; logic mr; logic fetch;} step_t;
  localparam vec_t PCOUT = 28'h1 << 27, PCIN = 28'h1 << 26, INCPC = 28'h1 << 25, MARIN = 28'h1 << 24;
  localparam vec_t MDRIN = 28'h1 << 23, MDROUT = 28'h1 << 22, IRIN = 28'h1 << 21, YIN = 28'h1 << 20;
  localparam vec_t ZIN = 28'h1 << 19, ZLOWOUT = 28'h1 << 18, READ = 28'h1 << 17, WRITE = 28'h1 << 16;
  localparam vec_t GRA = 28'h1 << 15, GRB = 28'h1 << 14, GRC = 28'h1 << 13, RIN = 28'h1 << 12;
  localparam vec_t ROUT = 28'h1 << 11, BAOUT = 28'h1 << 10, COUT = 28'h1 << 9, CONIN = 28'h1 << 8;
  localparam vec_t DONE = 28'h4, HALTED = 28'h2, FAULTED = 28'h1;
  logic clock = 1'b0;
  logic clear = 1'b0;
  int tests = 0;
  int failed = 0;
  step_t q[$];
  vec_t obs;
  control_sequencer_if #(.DATA_WIDTH(32)) ctl();
  control_sequencer dut (.clock(clock), .clear(clear), .bus(ctl));
  always #5 clock = ~clock;
  assign obs = {ctl.PCout, ctl.PCin, ctl.IncPC, ctl.MARin, ctl.MDRin, ctl.MDRout, ctl.IRin, ctl.Yin,
                ctl.Zin, ctl.Zlowout, ctl.Read, ctl.Write, ctl.Gra, ctl.Grb, ctl.Grc, ctl.Rin,
                ctl.Rout, ctl.BAout, ctl.Cout, ctl.CONin, ctl.alu_op, ctl.instr_done, ctl.halted, ctl.fault};
  function automatic vec_t alu(input logic [4:0] a);
    return {20'b0, a, 3'b0};
  endfunction
  function automatic bit runnable(input logic [4:0] o);
    return o <= 5'd14 || o == 5'd19 || o == 5'd26;
  endfunction
  task automatic check(input string tag, input vec_t o, input vec_t e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic push(input vec_t v, input bit fetch, input int waits);
    if (waits < 0) q.push_back('{v, 1'($urandom), fetch});
    else begin
      for (int i = 0; i < waits; i++) q.push_back('{v, 1'b0, fetch});
      q.push_back('{v, 1'b1, fetch});
    end
  endtask
  task automatic build(input logic [4:0] o, input logic con, input int w1, input int w2);
    q.delete();
    push(PCOUT | MARIN | INCPC | ZIN, 1, -1);
    push(ZLOWOUT | PCIN | READ | MDRIN, 1, w1);
    push(MDROUT | IRIN, 1, -1);
    if (o >= 3 && o <= 11) begin
      push(GRB | ROUT | YIN, 0, -1);
      push(GRC | ROUT | ZIN | alu(o), 0, -1);
      push(ZLOWOUT | GRA | RIN | DONE, 0, -1);
    end else if (o >= 12 && o <= 14) begin
      push(GRB | ROUT | YIN, 0, -1);
      push(COUT | ZIN | alu(o == 12 ? 5'd3 : o == 13 ? 5'd5 : 5'd6), 0, -1);
      push(ZLOWOUT | GRA | RIN | DONE, 0, -1);
    end else if (o <= 2) begin
      push(GRB | BAOUT | YIN, 0, -1);
      push(COUT | ZIN | alu(5'd3), 0, -1);
      if (o == 1) push(ZLOWOUT | GRA | RIN | DONE, 0, -1);
      else begin
        push(ZLOWOUT | MARIN, 0, -1);
        if (o == 0) begin
          push(READ | MDRIN, 0, w2);
          push(MDROUT | GRA | RIN | DONE, 0, -1);
        end else begin
          push(GRA | ROUT | MDRIN, 0, -1);
          push(WRITE | DONE, 0, w2);
        end
      end
    end else if (o == 19) begin
      push(GRA | ROUT | CONIN, 0, -1);
      push(PCOUT | YIN, 0, -1);
      push(COUT | ZIN | alu(5'd3), 0, -1);
      push((con ? ZLOWOUT | PCIN : '0) | DONE, 0, -1);
    end else if (o == 26) push(DONE, 0, -1);
    else begin
      push('0, 0, -1);
      for (int i = 0; i < 4; i++) push(o == 27 ? HALTED : FAULTED, 0, -1);
    end
  endtask
  task automatic exec(input logic [31:0] instr, input logic con, input int w1, input int w2,
                      input logic run_after, input string tag);
    build(instr[31:27], con, w1, w2);
    ctl.con_ff = con;
    foreach (q[i]) begin
      ctl.mem_ready = q[i].mr;
      ctl.ControlIn = q[i].fetch ? $urandom : instr;
      ctl.run = (i == q.size() - 1) ? run_after : 1'($urandom);
      @(negedge clock);
      check($sformatf("%s[%0d]", tag, i), obs, q[i].v);
      @(posedge clock);
      #1;
    end
  endtask
  task automatic idle(input int n);
    ctl.run = 1'b0;
    repeat (n) begin
      ctl.mem_ready = 1'($urandom);
      @(negedge clock);
      check("idle", obs, '0);
      @(posedge clock);
      #1;
    end
  endtask
  task automatic start();
    ctl.run = 1'b1;
    @(negedge clock);
    check("idle_run", obs, '0);
    @(posedge clock);
    #1;
  endtask
  initial begin
    logic [4:0] o;
    bit ra;
    ctl.run = 1'b0;
    ctl.mem_ready = 1'b0;
    ctl.con_ff = 1'b0;
    ctl.ControlIn = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset", obs, '0);
    clear = 1'b1;
    idle(2);
    start();
    exec(32'h18918000, 1'b0, 0, 0, 1'b1, "add");
    exec({5'd0, 27'($urandom)}, 1'b0, 3, 3, 1'b1, "ld_wait");
    exec({5'd2, 27'($urandom)}, 1'b0, 1, 2, 1'b1, "st_wait");
    exec({5'd19, 27'($urandom)}, 1'b0, 0, 0, 1'b1, "br_nt");
    exec({5'd19, 27'($urandom)}, 1'b1, 0, 0, 1'b1, "br_t");
    exec({5'd5, 27'($urandom)}, 1'b0, 0, 0, 1'b0, "run_drop");
    idle(3);
    start();
    ctl.mem_ready = 1'b0;
    @(negedge clock);
    check("t0_pre_clear", obs, PCOUT | MARIN | INCPC | ZIN);
    @(posedge clock);
    #1;
    @(negedge clock);
    check("t1_pre_clear", obs, ZLOWOUT | PCIN | READ | MDRIN);
    #2 clear = 1'b0;
    #1 check("async_clear", obs, '0);
    @(posedge clock);
    #1;
    check("held_clear", obs, '0);
    clear = 1'b1;
    start();
    exec({5'd13, 27'($urandom)}, 1'b0, 0, 0, 1'b1, "after_clear");
    for (int n = 0; n < 40; n++) begin
      do o = 5'($urandom); while (!runnable(o));
      ra = $urandom_range(0, 3) != 0;
      exec({o, 27'($urandom)}, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), ra,
           $sformatf("rnd%0d_op%0d", n, o));
      if (!ra) begin
        idle($urandom_range(1, 3));
        start();
      end
    end
    exec({5'd26, 27'($urandom)}, 1'b0, 0, 0, 1'b1, "nop");
    exec({5'd27, 27'($urandom)}, 1'b0, 1, 0, 1'b1, "halt");
    clear = 1'b0;
    #1 check("halt_clear", obs, '0);
    clear = 1'b1;
    idle(1);
    start();
    exec({5'd31, 27'($urandom)}, 1'b0, 0, 0, 1'b1, "fault");
    clear = 1'b0;
    #1 check("fault_clear", obs, '0);
    clear = 1'b1;
    idle(1);
    start();
    exec({5'd12, 27'($urandom)}, 1'b0, 2, 0, 1'b0, "recover");
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
